// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed hex display driver; define SEG7_LZ_BLANK_EN for leading-zero suppression
module seg7_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        page,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int DW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0]   held_q, up;
  logic          page_q, wrap, sup, dp_d, dp_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_d, an_q;
  logic [6:0]    seg_d, seg_q;
  always_comb begin
    wrap  = div_q == DW'(REFRESH_DIV - 1);
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = idx_q + {1'b0, wrap};
    up    = held_q >> {idx_q, 2'b00};
`ifdef SEG7_LZ_BLANK_EN
    sup   = idx_q != 2'd0 && up == 16'h0;
`else
    sup   = 1'b0;
`endif
    dp_d  = !(idx_q == 2'd3 && page_q);
    // a suppressed digit 3 stays enabled when its decimal point marks the upper page
    an_d  = (blank || (sup && dp_d)) ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = sup ? 7'h7F : HEX[up[3:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= '0;
      page_q <= 1'b0;
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      if (load) begin
        held_q <= value;
        page_q <= page;
      end
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench, two instances (REFRESH_DIV 4 and 1) against a frame-position model
module tb_seg7_scan;
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp;} exp_t;
  logic clk = 1'b0, reset = 1'b1, page = 1'b0, load = 1'b0, blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic dp4, dp1;
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  exp_t q4[$], q1[$];
  int checks = 0, errors = 0, n = 0;
  logic [15:0] mh = '0;
  logic mp = 1'b0;

  seg7_scan #(.REFRESH_DIV(4)) u4 (.clk(clk), .reset(reset), .value(value), .page(page), .load(load),
                                   .blank(blank), .an(an4), .seg(seg4), .dp(dp4));
  seg7_scan #(.REFRESH_DIV(1)) u1 (.clk(clk), .reset(reset), .value(value), .page(page), .load(load),
                                   .blank(blank), .an(an1), .seg(seg1), .dp(dp1));

  always #5 clk = ~clk;

  // n = edges since reset; the digit shown is simply which dwell slot of the frame we are in
  function automatic exp_t rf(int d_div);
    int d;
    logic [15:0] rest;
    logic s, dpl;
    exp_t e;
    if (reset) return {4'hF, 7'h7F, 1'b1};
    d    = (n / d_div) % 4;
    rest = mh >> (4 * d);
    s    = LZ && d > 0 && rest == 16'h0;
    dpl  = d == 3 && mp;
    e.an  = (blank || (s && !dpl)) ? 4'hF : ~(4'b0001 << d);
    e.seg = s ? 7'h7F : lut[rest[3:0]];
    e.dp  = !dpl;
    return e;
  endfunction

  always @(posedge clk) begin
    q4.push_back(rf(4));
    q1.push_back(rf(1));
    if (reset) begin
      n = 0; mh = '0; mp = 1'b0;
    end else begin
      n++;
      if (load) begin mh = value; mp = page; end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("an_div4", {4'h0, an4}, {4'h0, e.an});
      chk("seg_div4", {1'b0, seg4}, {1'b0, e.seg});
      chk("dp_div4", {7'h0, dp4}, {7'h0, e.dp});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("an_div1", {4'h0, an1}, {4'h0, e.an});
      chk("seg_div1", {1'b0, seg1}, {1'b0, e.seg});
      chk("dp_div1", {7'h0, dp1}, {7'h0, e.dp});
    end
  end

  task automatic drive(input logic r, input logic l, input logic [15:0] v, input logic p, input logic b);
    reset = r; load = l; value = v; page = p; blank = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k, input logic b);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, $urandom, $urandom, b);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    idle(40, 1'b0);
    drive(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
    idle(21, 1'b0);
    idle(10, 1'b1);
    idle(20, 1'b0);
    drive(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    idle(10, 1'b0);
    drive(1'b0, 1'b1, 16'h0F0F, 1'b0, 1'b0);
    idle(20, 1'b0);
    drive(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    idle(40, 1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle(40, 1'b0);
    drive(1'b0, 1'b1, 16'h00F0, 1'b1, 1'b0);
    idle(40, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) == 0) v = v >> (4 * $urandom_range(1, 3));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, v, $urandom, $urandom_range(0, 9) == 0);
    end
    idle(5, 1'b0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Downstream display stage for the FPGA ALU. Captures the ALU's 16-bit `out` word and drives a 4-digit, common-anode, time-multiplexed seven-segment display with its hexadecimal value. A page flag marks whether the upper or lower 16-bit half of the 32-bit result is shown. The block refreshes the display continuously, independently of ALU state changes.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit stays selected; legal range ≥ 1.
- `clk`  input  1  system clock; all logic on posedge.
- `reset`  input  1  synchronous, active-high; one clock domain.
- `value`  input  16  word to display (ALU `out`).
- `page`  input  1  0 = lower half shown, 1 = upper half shown.
- `load`  input  1  single-cycle strobe; captures `value` and `page`.
- `blank`  input  1  level; 1 forces all digits dark.
- `an`  output  4  digit enables, active-low, one-hot; `an[0]` = least significant digit.
- `seg`  output  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  output  1  decimal point, active-low.

## Operation
- Holding registers `held[15:0]` and `held_page` load on `load`=1. Without `load`, they keep their value.
- Divider `div` counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap cycle, digit index `idx` (2 bits) advances 0→1→2→3→0.
- With REFRESH_DIV=1, `idx` advances every cycle.
- Nibble select: `idx` n selects `held[4n+3:4n]`.
- Hex decode, active-low gfedcba:
  - 0 = 40h, 1 = 79h, 2 = 24h, 3 = 30h
  - 4 = 19h, 5 = 12h, 6 = 02h, 7 = 78h
  - 8 = 00h, 9 = 10h, A = 08h, b = 03h
  - C = 46h, d = 21h, E = 06h, F = 0Eh
- `an` = ~(1 << idx) when `blank`=0, otherwise 4'b1111.
- `dp` = 0 only when `idx`=3 and `held_page`=1; otherwise 1.
- Reset values:
  - `an` = 4'b1111, `seg` = 7'h7F, `dp` = 1
  - `held` = 0, `held_page` = 0, `div` = 0, `idx` = 0
- Simultaneous events:
  - `reset` together with `load`: reset wins, `held` = 0.
  - `load` on a divider-wrap cycle: both take effect. The new digit shows the new data.
- Reset mid-scan: the next cycle returns to the reset values. Scanning restarts at digit 0.
- `blank` does not stop `div` or `idx`. Scan phase is preserved across blanking.

## Timing
- `an`, `seg` and `dp` are registered. They are computed from the registered `idx` and `held`, so there is no combinational path from the inputs to the outputs.
- Latency:
  - `load` at edge N updates `held` at edge N; the selected digit reflects it at edge N+1.
  - `blank` asserted before edge N gives `an` = 1111 after edge N.
- First cycle after reset release: outputs still hold reset values. Digit 0 drives from the next edge.
- Dwell: each digit is active for exactly REFRESH_DIV cycles, so full frame = 4×REFRESH_DIV cycles.
- `an` transitions are glitch-free: exactly one bit is low per cycle while `blank`=0.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digit n (n = 1..3) is blanked (`an[n]` held 1) when it and every higher nibble of `held` are zero.
  - Digit 0 is never suppressed.
  - `dp` on digit 3 still lights when `held_page`=1, even if digit 3 is suppressed. In that case `an[3]`=0 and `seg` = 7'h7F.
- Not defined: all four digits are always shown, including leading zeros.

## Test plan
- Reset, then REFRESH_DIV=4, load `value`=16'h1234, `page`=0 → `an` cycles 1110, 1101, 1011, 0111 every 4 cycles with `seg` = 19h, 30h, 24h, 79h; `dp` stays 1.
- `value`=16'hABCD, `page`=1 → digit 3 shows `seg`=08h with `dp`=0; `dp`=1 on digits 0–2; digit 0 shows 21h.
- `blank`=1 for 10 cycles mid-frame → `an`=1111 one edge later. After release, scan resumes at the `idx` it would have reached without blanking.
- `reset` asserted during digit 2 with `load`=1, `value`=FFFFh → next cycle `an`=1111, `seg`=7Fh, `held`=0; one edge after release, digit 0 shows 40h.
- REFRESH_DIV=1, `value`=0F0Fh → `an` changes every cycle; `seg` alternates 0Eh and 40h.
- With `SEG7_LZ_BLANK_EN`, `value`=0005h → only `an[0]` ever goes low, with `seg`=12h. Then `value`=0000h, `page`=1 → `an[0]` shows 40h; `an[3]` goes low with `seg`=7Fh, `dp`=0.
